// File: rtl/can_tx_loader_pkg.sv
// Shared types, register constants and frame-image helpers for the CAN TX frame loader.
// Frame image layout: control byte, ID bytes (4 extended / 2 standard), then payload bytes.
package can_tx_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CMD,
        WAIT_DONE,
        ABORT,
        RESP
    } state_e;

    localparam logic [7:0] CMD_ADDR = 8'd1;
    localparam logic [7:0] CMD_TR   = 8'h01;
    localparam logic [7:0] CMD_AT   = 8'h02;

    // Payload length is clamped to 8 bytes; RTR frames carry no payload.
    function automatic logic [3:0] frame_len(input logic ext, input logic rtr, input logic [3:0] dlc);
        logic [3:0] nd;
        nd = rtr ? 4'd0 : ((dlc > 4'd8) ? 4'd8 : dlc);
        return 4'd1 + (ext ? 4'd4 : 4'd2) + nd;
    endfunction

    function automatic logic [7:0] frame_byte(input logic [28:0] id, input logic ext, input logic rtr,
                                              input logic [3:0] dlc, input logic [63:0] data,
                                              input logic [3:0] idx);
        logic [2:0] dpos;
        logic [7:0] b;
        b    = 8'h00;
        dpos = 3'(idx - (ext ? 4'd5 : 4'd3));
        if (idx == 4'd0) begin
            b = {ext, rtr, 2'b00, dlc};
        end else if (ext && idx <= 4'd4) begin
            case (idx)
                4'd1:    b = id[28:21];
                4'd2:    b = id[20:13];
                4'd3:    b = id[12:5];
                default: b = {id[4:0], 3'b000};
            endcase
        end else if (!ext && idx <= 4'd2) begin
            b = (idx == 4'd1) ? id[10:3] : {id[2:0], 5'b00000};
        end else begin
            b = data[{dpos, 3'b000} +: 8];
        end
        return b;
    endfunction

endpackage

// File: rtl/can_tx_timeout_cnt.sv
// Counts consecutive enabled cycles; expired_o flags the LIMIT-th one (combinational, same cycle).
// Clears whenever en_i drops, so each WAIT_DONE visit starts from zero.
module can_tx_timeout_cnt #(
    parameter int LIMIT = 200000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d     = '0;
        expired_o = en_i && (cnt_q == W'(LIMIT - 1));
        if (en_i && !expired_o) begin
            cnt_d = cnt_q + W'(1);
        end else if (en_i) begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

endmodule

// File: rtl/can_tx_frame_loader.sv
// Writes one CAN frame image into the controller TX buffer (1 byte/cycle, first write the cycle after accept),
// then issues transmission request; req_ready_o only in IDLE. Optional WAIT_DONE timeout: CAN_TX_LOADER_TIMEOUT_EN.
module can_tx_frame_loader
    import can_tx_loader_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [28:0] id_i,
    input  logic        ext_i,
    input  logic        rtr_i,
    input  logic [3:0]  dlc_i,
    input  logic [63:0] data_i,
    output logic        tx_we_o,
    output logic [3:0]  tx_addr_o,
    output logic [7:0]  tx_data_o,
    output logic        reg_we_o,
    output logic [7:0]  reg_addr_write_o,
    output logic [7:0]  reg_data_o,
    input  logic        tx_done_i,
    output logic        resp_valid_o,
    output logic        resp_ok_o
);
    state_e      state_q, state_d;
    logic [28:0] id_q, id_d;
    logic        ext_q, ext_d;
    logic        rtr_q, rtr_d;
    logic [3:0]  dlc_q, dlc_d;
    logic [63:0] data_q, data_d;
    logic [3:0]  len_q, len_d;
    logic [3:0]  idx_q, idx_d;
    logic        ok_q, ok_d;

`ifdef CAN_TX_LOADER_TIMEOUT_EN
    logic timeout;

    can_tx_timeout_cnt #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .en_i      (state_q == WAIT_DONE),
        .expired_o (timeout)
    );
`else
    logic unused_cfg;
    assign unused_cfg = ^{TIMEOUT_CYCLES, CMD_AT};
`endif

    always_comb begin
        state_d          = state_q;
        id_d             = id_q;
        ext_d            = ext_q;
        rtr_d            = rtr_q;
        dlc_d            = dlc_q;
        data_d           = data_q;
        len_d            = len_q;
        idx_d            = idx_q;
        ok_d             = ok_q;
        req_ready_o      = 1'b0;
        tx_we_o          = 1'b0;
        tx_addr_o        = 4'd0;
        tx_data_o        = 8'h00;
        reg_we_o         = 1'b0;
        reg_addr_write_o = 8'h00;
        reg_data_o       = 8'h00;
        resp_valid_o     = 1'b0;
        resp_ok_o        = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    id_d    = id_i;
                    ext_d   = ext_i;
                    rtr_d   = rtr_i;
                    dlc_d   = dlc_i;
                    data_d  = data_i;
                    len_d   = frame_len(ext_i, rtr_i, dlc_i);
                    idx_d   = 4'd0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                tx_we_o   = 1'b1;
                tx_addr_o = idx_q;
                tx_data_o = frame_byte(id_q, ext_q, rtr_q, dlc_q, data_q, idx_q);
                idx_d     = idx_q + 4'd1;
                if (idx_q == len_q - 4'd1) state_d = CMD;
            end
            CMD: begin
                reg_we_o         = 1'b1;
                reg_addr_write_o = CMD_ADDR;
                reg_data_o       = CMD_TR;
                state_d          = WAIT_DONE;
            end
            WAIT_DONE: begin
                // A completion arriving on the timeout cycle still counts as success.
                if (tx_done_i) begin
                    ok_d    = 1'b1;
                    state_d = RESP;
                end
`ifdef CAN_TX_LOADER_TIMEOUT_EN
                else if (timeout) begin
                    state_d = ABORT;
                end
`endif
            end
`ifdef CAN_TX_LOADER_TIMEOUT_EN
            ABORT: begin
                reg_we_o         = 1'b1;
                reg_addr_write_o = CMD_ADDR;
                reg_data_o       = CMD_AT;
                ok_d             = 1'b0;
                state_d          = RESP;
            end
`endif
            RESP: begin
                resp_valid_o = 1'b1;
                resp_ok_o    = ok_q;
                ok_d         = 1'b0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            id_q    <= '0;
            ext_q   <= 1'b0;
            rtr_q   <= 1'b0;
            dlc_q   <= '0;
            data_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            ext_q   <= ext_d;
            rtr_q   <= rtr_d;
            dlc_q   <= dlc_d;
            data_q  <= data_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            ok_q    <= ok_d;
        end
    end

endmodule

// File: tb/tb_can_tx_frame_loader.sv
// Bench for can_tx_frame_loader: directed frame table, random frames against a byte-list model, reset and timeout cases.
module tb_can_tx_frame_loader;
    localparam int TO = 50;

    logic        clk = 1'b0;
    logic        rst_n_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [28:0] id_i;
    logic        ext_i;
    logic        rtr_i;
    logic [3:0]  dlc_i;
    logic [63:0] data_i;
    logic        tx_we_o;
    logic [3:0]  tx_addr_o;
    logic [7:0]  tx_data_o;
    logic        reg_we_o;
    logic [7:0]  reg_addr_write_o;
    logic [7:0]  reg_data_o;
    logic        tx_done_i;
    logic        resp_valid_o;
    logic        resp_ok_o;

    int nchk = 0;
    int nfail = 0;

    can_tx_frame_loader #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n_i),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .id_i             (id_i),
        .ext_i            (ext_i),
        .rtr_i            (rtr_i),
        .dlc_i            (dlc_i),
        .data_i           (data_i),
        .tx_we_o          (tx_we_o),
        .tx_addr_o        (tx_addr_o),
        .tx_data_o        (tx_data_o),
        .reg_we_o         (reg_we_o),
        .reg_addr_write_o (reg_addr_write_o),
        .reg_data_o       (reg_data_o),
        .tx_done_i        (tx_done_i),
        .resp_valid_o     (resp_valid_o),
        .resp_ok_o        (resp_ok_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [28:0]  id;
        logic         ext;
        logic         rtr;
        logic [3:0]   dlc;
        logic [63:0]  data;
        int           n;
        logic [103:0] eb;
    } vec_t;

    vec_t vt[4];

    task automatic check(input bit ok, input string nm, input logic [127:0] act, input logic [127:0] exp);
        nchk++;
        if (!ok) begin
            nfail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Frame image as an ordered byte list built from the field rules.
    function automatic void model(input logic [28:0] id, input logic ext, input logic rtr,
                                  input logic [3:0] dlc, input logic [63:0] data,
                                  output int n, output logic [103:0] eb);
        logic [7:0] q[$];
        int nd;
        q.push_back({ext, rtr, 2'b00, dlc});
        if (ext) begin
            q.push_back(8'(id >> 21));
            q.push_back(8'(id >> 13));
            q.push_back(8'(id >> 5));
            q.push_back(8'(id << 3));
        end else begin
            q.push_back(8'(id >> 3));
            q.push_back(8'(id << 5));
        end
        nd = rtr ? 0 : ((int'(dlc) > 8) ? 8 : int'(dlc));
        for (int k = 0; k < nd; k++) q.push_back(8'(data >> (8 * k)));
        n  = q.size();
        eb = '0;
        for (int i = 0; i < n; i++) eb[8*i +: 8] = q[i];
    endfunction

    // Starts and ends one clock after a rising edge. delay<0: never complete (expects abort).
    task automatic do_frame(input logic [28:0] id, input logic ext, input logic rtr, input logic [3:0] dlc,
                            input logic [63:0] data, input int n, input logic [103:0] eb,
                            input int delay, input bit spur);
        id_i = id; ext_i = ext; rtr_i = rtr; dlc_i = dlc; data_i = data;
        req_valid_i = 1'b1;
        @(negedge clk);
        check(req_ready_o == 1'b1, "accept_ready", req_ready_o, 1);
        tick();
        req_valid_i = 1'b0;
        id_i = 29'($urandom); ext_i = ~ext; rtr_i = ~rtr; dlc_i = ~dlc; data_i = {$urandom, $urandom};
        for (int i = 0; i < n; i++) begin
            if (spur && i == 0) tx_done_i = 1'b1;
            @(negedge clk);
            check(tx_we_o && tx_addr_o == 4'(i) && tx_data_o == eb[8*i +: 8], "load_byte",
                  {tx_we_o, tx_addr_o, tx_data_o}, {1'b1, 4'(i), eb[8*i +: 8]});
            tick();
            tx_done_i = 1'b0;
        end
        if (spur) tx_done_i = 1'b1;
        @(negedge clk);
        check(!tx_we_o && reg_we_o && reg_addr_write_o == 8'd1 && reg_data_o == 8'h01, "cmd_tr",
              {tx_we_o, reg_we_o, reg_addr_write_o, reg_data_o}, {1'b0, 1'b1, 8'd1, 8'h01});
        tick();
        tx_done_i = 1'b0;
        if (delay < 0) begin
            for (int w = 0; w < TO; w++) begin
                @(negedge clk);
                check(!tx_we_o && !reg_we_o && !resp_valid_o && !req_ready_o, "wait_quiet",
                      {tx_we_o, reg_we_o, resp_valid_o, req_ready_o}, 0);
                tick();
            end
            @(negedge clk);
            check(!tx_we_o && reg_we_o && reg_addr_write_o == 8'd1 && reg_data_o == 8'h02, "abort_cmd",
                  {tx_we_o, reg_we_o, reg_addr_write_o, reg_data_o}, {1'b0, 1'b1, 8'd1, 8'h02});
            tick();
        end else begin
            for (int w = 0; w <= delay; w++) begin
                if (w == delay) tx_done_i = 1'b1;
                @(negedge clk);
                check(!tx_we_o && !reg_we_o && !resp_valid_o && !req_ready_o, "wait_quiet",
                      {tx_we_o, reg_we_o, resp_valid_o, req_ready_o}, 0);
                tick();
                tx_done_i = 1'b0;
            end
        end
        @(negedge clk);
        check(resp_valid_o && resp_ok_o == (delay >= 0) && !reg_we_o, "resp",
              {resp_valid_o, resp_ok_o, reg_we_o}, {1'b1, delay >= 0, 1'b0});
        tick();
        @(negedge clk);
        check(req_ready_o && !resp_valid_o && !tx_we_o && !reg_we_o, "back_idle",
              {req_ready_o, resp_valid_o, tx_we_o, reg_we_o}, 4'b1000);
        tick();
    endtask

    initial begin
        int          n;
        logic [103:0] eb;
        logic [28:0] rid;
        logic        rext, rrtr;
        logic [3:0]  rdlc;
        logic [63:0] rdata;

        vt[0] = '{29'h12345678, 1'b1, 1'b0, 4'd8, 64'h8877665544332211, 13,
                  {8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11, 8'hC0, 8'hB3, 8'hA2, 8'h91, 8'h88}};
        vt[1] = '{29'h123, 1'b0, 1'b0, 4'd2, 64'hBBAA, 5, {64'h0, 8'hBB, 8'hAA, 8'h60, 8'h24, 8'h02}};
        vt[2] = '{29'h1ABCDEF0, 1'b1, 1'b1, 4'd4, 64'hDEADBEEFCAFEF00D, 5,
                  {64'h0, 8'h80, 8'hF7, 8'hE6, 8'hD5, 8'hC4}};
        vt[3] = '{29'h7FF, 1'b0, 1'b0, 4'd15, 64'h0807060504030201, 11,
                  {16'h0, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'hE0, 8'hFF, 8'h0F}};

        rst_n_i = 1'b0; req_valid_i = 1'b0; tx_done_i = 1'b0;
        id_i = '0; ext_i = 1'b0; rtr_i = 1'b0; dlc_i = '0; data_i = '0;
        repeat (3) @(posedge clk);
        #1 rst_n_i = 1'b1;
        @(negedge clk);
        check(req_ready_o == 1'b1, "rst_ready", req_ready_o, 1);
        check({tx_we_o, tx_addr_o, tx_data_o} == '0, "rst_tx", {tx_we_o, tx_addr_o, tx_data_o}, 0);
        check({reg_we_o, reg_addr_write_o, reg_data_o} == '0, "rst_reg", {reg_we_o, reg_addr_write_o, reg_data_o}, 0);
        check({resp_valid_o, resp_ok_o} == 2'b00, "rst_resp", {resp_valid_o, resp_ok_o}, 0);
        tick();

        tx_done_i = 1'b1;
        tick();
        tx_done_i = 1'b0;
        @(negedge clk);
        check(!resp_valid_o && req_ready_o && !reg_we_o, "idle_done_ignored", {resp_valid_o, req_ready_o, reg_we_o}, 3'b010);
        tick();

        for (int i = 0; i < 4; i++) do_frame(vt[i].id, vt[i].ext, vt[i].rtr, vt[i].dlc, vt[i].data,
                                             vt[i].n, vt[i].eb, i + 1, i == 1);

        // Reset during the third LOAD write of the standard frame.
        id_i = 29'h123; ext_i = 1'b0; rtr_i = 1'b0; dlc_i = 4'd2; data_i = 64'hBBAA;
        req_valid_i = 1'b1;
        tick();
        req_valid_i = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check(tx_we_o && tx_addr_o == 4'd2, "pre_rst_load", {tx_we_o, tx_addr_o}, {1'b1, 4'd2});
        #2 rst_n_i = 1'b0;
        #1;
        check(!tx_we_o && !reg_we_o && !resp_valid_o, "rst_async_drop", {tx_we_o, reg_we_o, resp_valid_o}, 0);
        tick();
        tick();
        rst_n_i = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check(req_ready_o && !tx_we_o && !reg_we_o && !resp_valid_o, "post_rst_idle",
                  {req_ready_o, tx_we_o, reg_we_o, resp_valid_o}, 4'b1000);
            tick();
        end

        for (int r = 0; r < 30; r++) begin
            rid = 29'($urandom); rext = 1'($urandom); rrtr = ($urandom_range(0, 3) == 0);
            rdlc = 4'($urandom_range(0, 15)); rdata = {$urandom, $urandom};
            model(rid, rext, rrtr, rdlc, rdata, n, eb);
            do_frame(rid, rext, rrtr, rdlc, rdata, n, eb, $urandom_range(0, 6), 1'($urandom));
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                check(req_ready_o && !tx_we_o && !reg_we_o, "gap_idle", {req_ready_o, tx_we_o, reg_we_o}, 3'b100);
                tick();
            end
        end

`ifdef CAN_TX_LOADER_TIMEOUT_EN
        model(29'h12345678, 1'b1, 1'b0, 4'd8, 64'h8877665544332211, n, eb);
        do_frame(29'h12345678, 1'b1, 1'b0, 4'd8, 64'h8877665544332211, n, eb, -1, 1'b0);
        do_frame(29'h12345678, 1'b1, 1'b0, 4'd8, 64'h8877665544332211, n, eb, TO - 1, 1'b0);
`else
        model(29'h0ABCDE, 1'b0, 1'b0, 4'd3, 64'h334455, n, eb);
        do_frame(29'h0ABCDE, 1'b0, 1'b0, 4'd3, 64'h334455, n, eb, 300, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/can_tx_frame_loader.md
CAN_TX_FRAME_LOADER -- requirements
Module: can_tx_frame_loader

Interface
- REQ-001 Parameter TIMEOUT_CYCLES, default 200000: WAIT_DONE cycle limit (used only when CAN_TX_LOADER_TIMEOUT_EN is defined).
- REQ-002 Ports: clk_i, input, 1, system clock; all logic rising-edge.
- REQ-003 Ports: rst_n_i, input, 1, reset, asynchronous, active-low.
- REQ-004 Ports: req_valid_i / req_ready_o, in/out, 1/1, frame request handshake.
- REQ-005 Ports: id_i, ext_i, rtr_i, dlc_i, data_i, input, 29/1/1/4/64: ID, extended flag, RTR, DLC, payload (byte n = data_i[8n+7:8n]).
- REQ-006 Ports: tx_we_o, tx_addr_o, tx_data_o, output, 1/4/8: controller TX-buffer write port.
- REQ-007 Ports: reg_we_o, reg_addr_write_o, reg_data_o, output, 1/8/8: controller register write port.
- REQ-008 Ports: tx_done_i, input, 1: single-cycle transmit-complete pulse from the controller.
- REQ-009 Ports: resp_valid_o / resp_ok_o, output, 1/1: completion pulse and status.

Function
- REQ-010 FSM states SHALL be IDLE, LOAD, CMD, WAIT_DONE, ABORT, RESP.
- REQ-011 req_ready_o SHALL be 1 only in IDLE; the handshake captures all frame inputs and moves to LOAD.
- REQ-012 LOAD SHALL assert tx_we_o for exactly N consecutive cycles, tx_addr_o incrementing 0..N-1, one byte per cycle.
- REQ-013 N SHALL be 1 + (ext ? 4 : 2) + (rtr ? 0 : min(dlc,8)); DLC 9..15 clamps to 8 data bytes, and raw dlc goes into byte 0.
- REQ-014 Byte 0 SHALL be {ext, rtr, 2'b00, dlc}.
- REQ-015 Extended ID bytes SHALL be id[28:21], id[20:13], id[12:5], {id[4:0],3'b000}.
- REQ-016 Standard ID bytes SHALL be id[10:3], {id[2:0],5'b00000}; id[28:11] ignored.
- REQ-017 Data bytes SHALL follow the ID bytes, byte 0 first.
- REQ-018 CMD SHALL last one cycle with reg_we_o=1, reg_addr_write_o=8'd1, reg_data_o=8'h01 (transmission request), then enter WAIT_DONE.
- REQ-019 WAIT_DONE SHALL exit on tx_done_i=1 to RESP with resp_ok_o=1.
- REQ-020 tx_done_i outside WAIT_DONE SHALL be ignored.
- REQ-021 RESP SHALL last one cycle with resp_valid_o=1, then return to IDLE.
- REQ-022 Latency from handshake cycle: first tx_we_o on the next cycle; CMD at cycle N+1; response 1 cycle after tx_done_i.
- REQ-023 Outside LOAD/CMD/ABORT, tx_we_o and reg_we_o SHALL be 0; address/data outputs are don't-care when their write enable is 0.

Reset
- REQ-024 rst_n_i low SHALL force IDLE immediately, mid-operation included, with no further writes issued.
- REQ-025 Reset values: req_ready_o=1 after release; all other outputs 0; captured frame and counters 0.
- REQ-026 TX-buffer contents after a mid-load reset are unspecified.

Configuration
- REQ-027 Macro CAN_TX_LOADER_TIMEOUT_EN defined: a counter runs in WAIT_DONE; at TIMEOUT_CYCLES without tx_done_i the FSM enters ABORT.
- REQ-028 ABORT SHALL last one cycle writing reg 1 with 8'h02 (abort transmission), then go to RESP with resp_ok_o=0.
- REQ-029 tx_done_i coinciding with the timeout cycle SHALL win (resp_ok_o=1).
- REQ-030 Macro undefined: no counter or ABORT logic; WAIT_DONE waits indefinitely.

Structure
- REQ-031 Package can_tx_loader_pkg SHALL hold the state enum, register address constants (CMD_ADDR=1), and command values (CMD_TR=8'h01, CMD_AT=8'h02).
- REQ-032 The timeout counter SHALL be sub-module can_tx_timeout_cnt, instantiated only under CAN_TX_LOADER_TIMEOUT_EN.

Verification
- REQ-033 Extended frame, id=29'h12345678, dlc=8, data=64'h8877665544332211: 13 writes at addr 0..12 = 88,91,A2,B3,C0,11,22..88; then reg1<=01.
- REQ-034 Standard frame, id=11'h123, dlc=2, data=16'hBBAA: 5 writes = 02,24,60,AA,BB.
- REQ-035 RTR extended, dlc=4: exactly 5 writes, byte 0 = C4.
- REQ-036 dlc=15: 8 data bytes written, byte 0 low nibble = F.
- REQ-037 Reset asserted at 3rd LOAD write: tx_we_o drops the same cycle; after release req_ready_o=1 with no CMD issued.
- REQ-038 With CAN_TX_LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=50, no tx_done_i: reg1<=02 after 50 WAIT_DONE cycles, then resp_valid_o=1, resp_ok_o=0; a tx_done_i on cycle 50 gives resp_ok_o=1.
